// File: rtl/ddr_wr_burst_arbiter.sv
// rtl/ddr_wr_burst_arbiter.sv - two-client write-burst arbiter in front of the DDR controller port
// Grants one client per burst, latches its command and steers data_req/data/finish.
module ddr_wr_burst_arbiter #(
  parameter int ADDR_W     = 27,
  parameter int LEN_W      = 10,
  parameter int DATA_W     = 64,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 4096
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              c0_wr_burst_req,
  input  logic [ADDR_W-1:0] c0_wr_burst_addr,
  input  logic [LEN_W-1:0]  c0_wr_burst_len,
  input  logic [DATA_W-1:0] c0_wr_burst_data,
  output logic              c0_wr_burst_data_req,
  output logic              c0_burst_finish,
  input  logic              c1_wr_burst_req,
  input  logic [ADDR_W-1:0] c1_wr_burst_addr,
  input  logic [LEN_W-1:0]  c1_wr_burst_len,
  input  logic [DATA_W-1:0] c1_wr_burst_data,
  output logic              c1_wr_burst_data_req,
  output logic              c1_burst_finish,
  output logic              wr_burst_req,
  output logic [ADDR_W-1:0] wr_burst_addr,
  output logic [LEN_W-1:0]  wr_burst_len,
  output logic [DATA_W-1:0] wr_burst_data,
  input  logic              wr_burst_data_req,
  input  logic              burst_finish,
  output logic [1:0]        grant,
  output logic              arb_error
);
  localparam int               TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE, DONE} state_t;

  state_t            state;
  logic              rr_ptr;  // client that wins when both request
  logic              owner;
  logic [LEN_W-1:0]  beat_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic              pick;
  logic              busy;
  logic              tmo_hit;
  logic              err_set;
  logic [ADDR_W-1:0] pick_addr;
  logic [LEN_W-1:0]  pick_len;
  logic [LEN_W-1:0]  beat_next;

  always_comb begin
    pick = 1'b0;
    if (c0_wr_burst_req && c1_wr_burst_req) begin
      pick = (FIXED_PRIO != 0) ? 1'b0 : rr_ptr;
    end else begin
      pick = c1_wr_burst_req;
    end
    pick_addr = pick ? c1_wr_burst_addr : c0_wr_burst_addr;
    pick_len  = pick ? c1_wr_burst_len : c0_wr_burst_len;
    busy      = (state != IDLE);
    beat_next = beat_cnt + LEN_W'(wr_burst_data_req);
    tmo_hit   = busy && (tmo_cnt == TMO_MAX);
    // Protocol violations by the controller, plus a stuck burst
    err_set   = (!busy && (wr_burst_data_req || burst_finish))
             || (busy && wr_burst_data_req && (beat_cnt == wr_burst_len))
             || (burst_finish && (state == ISSUE || state == ACTIVE) && (beat_next != wr_burst_len))
             || tmo_hit;
  end

  assign c0_wr_burst_data_req = wr_burst_data_req & grant[0];
  assign c1_wr_burst_data_req = wr_burst_data_req & grant[1];
  assign wr_burst_data = grant[0] ? c0_wr_burst_data :
                         grant[1] ? c1_wr_burst_data : '0;

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      rr_ptr          <= 1'b0;
      owner           <= 1'b0;
      beat_cnt        <= '0;
      tmo_cnt         <= '0;
      grant           <= 2'b00;
      wr_burst_req    <= 1'b0;
      wr_burst_addr   <= '0;
      wr_burst_len    <= '0;
      c0_burst_finish <= 1'b0;
      c1_burst_finish <= 1'b0;
      arb_error       <= 1'b0;
    end else begin
      c0_burst_finish <= 1'b0;
      c1_burst_finish <= 1'b0;
      if (err_set) arb_error <= 1'b1;
      if (busy && wr_burst_data_req && (beat_cnt != '1)) beat_cnt <= beat_cnt + 1'b1;
      if (busy && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (c0_wr_burst_req || c1_wr_burst_req) begin
            owner         <= pick;
            grant         <= pick ? 2'b10 : 2'b01;
            wr_burst_addr <= pick_addr;
            wr_burst_len  <= pick_len;
            beat_cnt      <= '0;
            tmo_cnt       <= '0;
            // A zero-length burst never reaches the controller
            if (pick_len == '0) begin
              state <= DONE;
            end else begin
              wr_burst_req <= 1'b1;
              state        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (burst_finish) begin
            wr_burst_req <= 1'b0;
            state        <= DONE;
          end else if (wr_burst_data_req) begin
            wr_burst_req <= 1'b0;
            state        <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (burst_finish) state <= DONE;
        end
        DONE: begin
          if (owner) c1_burst_finish <= 1'b1;
          else       c0_burst_finish <= 1'b1;
          rr_ptr <= ~owner;
          grant  <= 2'b00;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_wr_burst_arbiter.sv
// tb/tb_ddr_wr_burst_arbiter.sv - self-checking bench for ddr_wr_burst_arbiter
// Round-robin and fixed-priority instances share stimulus; sel picks the one being checked.
module tb_ddr_wr_burst_arbiter;
  localparam int AW  = 27;
  localparam int LW  = 10;
  localparam int DW  = 64;
  localparam int TMO = 300;

  logic          mem_clk = 1'b0;
  logic          rst_n;
  logic          c0_req, c1_req;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [LW-1:0] c0_len, c1_len;
  logic [DW-1:0] c0_data, c1_data;
  logic          dreq, fin;

  logic          r_c0dr, r_c0fin, r_c1dr, r_c1fin, r_req, r_err;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_len;
  logic [DW-1:0] r_data;
  logic [1:0]    r_grant;
  logic          f_c0dr, f_c0fin, f_c1dr, f_c1fin, f_req, f_err;
  logic [AW-1:0] f_addr;
  logic [LW-1:0] f_len;
  logic [DW-1:0] f_data;
  logic [1:0]    f_grant;

  logic          sel;
  logic          m_c0dr, m_c0fin, m_c1dr, m_c1fin, m_req, m_err;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  logic [DW-1:0] m_data;
  logic [1:0]    m_grant;

  assign m_c0dr  = sel ? f_c0dr  : r_c0dr;
  assign m_c0fin = sel ? f_c0fin : r_c0fin;
  assign m_c1dr  = sel ? f_c1dr  : r_c1dr;
  assign m_c1fin = sel ? f_c1fin : r_c1fin;
  assign m_req   = sel ? f_req   : r_req;
  assign m_err   = sel ? f_err   : r_err;
  assign m_addr  = sel ? f_addr  : r_addr;
  assign m_len   = sel ? f_len   : r_len;
  assign m_data  = sel ? f_data  : r_data;
  assign m_grant = sel ? f_grant : r_grant;

  always #5 mem_clk = ~mem_clk;

  ddr_wr_burst_arbiter #(.ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .FIXED_PRIO(0), .TIMEOUT(TMO)) u_rr (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .c0_wr_burst_req(c0_req), .c0_wr_burst_addr(c0_addr), .c0_wr_burst_len(c0_len),
    .c0_wr_burst_data(c0_data), .c0_wr_burst_data_req(r_c0dr), .c0_burst_finish(r_c0fin),
    .c1_wr_burst_req(c1_req), .c1_wr_burst_addr(c1_addr), .c1_wr_burst_len(c1_len),
    .c1_wr_burst_data(c1_data), .c1_wr_burst_data_req(r_c1dr), .c1_burst_finish(r_c1fin),
    .wr_burst_req(r_req), .wr_burst_addr(r_addr), .wr_burst_len(r_len), .wr_burst_data(r_data),
    .wr_burst_data_req(dreq), .burst_finish(fin), .grant(r_grant), .arb_error(r_err)
  );

  ddr_wr_burst_arbiter #(.ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .FIXED_PRIO(1), .TIMEOUT(TMO)) u_fx (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .c0_wr_burst_req(c0_req), .c0_wr_burst_addr(c0_addr), .c0_wr_burst_len(c0_len),
    .c0_wr_burst_data(c0_data), .c0_wr_burst_data_req(f_c0dr), .c0_burst_finish(f_c0fin),
    .c1_wr_burst_req(c1_req), .c1_wr_burst_addr(c1_addr), .c1_wr_burst_len(c1_len),
    .c1_wr_burst_data(c1_data), .c1_wr_burst_data_req(f_c1dr), .c1_burst_finish(f_c1fin),
    .wr_burst_req(f_req), .wr_burst_addr(f_addr), .wr_burst_len(f_len), .wr_burst_data(f_data),
    .wr_burst_data_req(dreq), .burst_finish(fin), .grant(f_grant), .arb_error(f_err)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_dr0 = 0, n_dr1 = 0, n_rq = 0, n_bad = 0, tf0 = 0, tf1 = 0;

  always @(negedge mem_clk) begin
    if (m_c0dr) begin
      n_dr0++;
      if (m_data !== c0_data) n_bad++;
    end
    if (m_c1dr) begin
      n_dr1++;
      if (m_data !== c1_data) n_bad++;
    end
    if (m_req) n_rq++;
    if (m_c0fin) tf0++;
    if (m_c1fin) tf1++;
  end

  // Reference model: last client served, sticky error, finish pulses expected per phase
  logic last;
  logic exp_err;
  int   ef0, ef1, bf0, bf1;

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    c0_req = 1'b0;
    c1_req = 1'b0;
    dreq   = 1'b0;
    fin    = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    last    = 1'b1;
    exp_err = 1'b0;
  endtask

  task automatic phase_start();
    bf0 = tf0;
    bf1 = tf1;
    ef0 = 0;
    ef1 = 0;
  endtask

  task automatic phase_end(input string tag);
    c0_req = 1'b0;
    c1_req = 1'b0;
    tick();
    tick();
    chk({tag, "_fin0_total"}, 64'(tf0 - bf0), 64'(ef0));
    chk({tag, "_fin1_total"}, 64'(tf1 - bf1), 64'(ef1));
  endtask

  // One burst: predict winner from current requests, act as controller, check outcome.
  task automatic burst(input string tag, input int beats_in, input int lat, input int gap, input bit hold0);
    logic [1:0]    w;
    logic [AW-1:0] ea;
    logic [LW-1:0] el;
    int beats, t, b0, b1, brq, bbad, nw, no;
    if (c0_req && c1_req) w = (sel || last) ? 2'b01 : 2'b10;
    else                  w = c0_req ? 2'b01 : 2'b10;
    ea    = w[0] ? c0_addr : c1_addr;
    el    = w[0] ? c0_len : c1_len;
    beats = (beats_in < 0) ? int'(el) : beats_in;
    t = 0;
    do begin
      tick();
      t++;
    end while (m_grant == 2'b00 && t < 40);
    chk({tag, "_wait"}, 64'(t), 64'd1);
    chk({tag, "_grant"}, 64'(m_grant), 64'(w));
    chk({tag, "_addr"}, 64'(m_addr), 64'(ea));
    chk({tag, "_len"}, 64'(m_len), 64'(el));
    chk({tag, "_req_at_grant"}, 64'(m_req), 64'(el != 0));
    b0 = n_dr0; b1 = n_dr1; brq = n_rq; bbad = n_bad;
    if (!(hold0 && w[0])) begin
      if (w[0]) c0_req = 1'b0;
      else      c1_req = 1'b0;
    end
    if (el != 0) begin
      repeat (lat) tick();
      for (int i = 0; i < beats; i++) begin
        dreq    = 1'b1;
        c0_data = {$urandom, $urandom};
        c1_data = {$urandom, $urandom};
        tick();
      end
      dreq = 1'b0;
      repeat (gap) tick();
      fin = 1'b1;
      tick();
      fin = 1'b0;
      if (beats != int'(el) || lat + beats + gap + 1 >= TMO) exp_err = 1'b1;
    end
    t = 0;
    while (!(m_c0fin || m_c1fin) && t < 8) begin
      tick();
      t++;
    end
    chk({tag, "_fin_owner"}, 64'({m_c1fin, m_c0fin}), 64'(w));
    chk({tag, "_fin_delay"}, 64'(t), 64'd1);
    chk({tag, "_grant_cleared"}, 64'(m_grant), 64'd0);
    nw = w[0] ? n_dr0 - b0 : n_dr1 - b1;
    no = w[0] ? n_dr1 - b1 : n_dr0 - b0;
    chk({tag, "_owner_beats"}, 64'(nw), 64'((el != 0) ? beats : 0));
    chk({tag, "_other_beats"}, 64'(no), 64'd0);
    chk({tag, "_req_cycles"}, 64'(n_rq - brq), 64'((el != 0) ? lat + 1 : 0));
    chk({tag, "_data"}, 64'(n_bad - bbad), 64'd0);
    chk({tag, "_err"}, 64'(m_err), 64'(exp_err));
    last = w[1];
    if (w[0]) ef0++;
    else      ef1++;
  endtask

  int t;
  int r;

  initial begin
    sel = 1'b0;
    rst_n = 1'b0;
    c0_req = 1'b0; c1_req = 1'b0; dreq = 1'b0; fin = 1'b0;
    c0_addr = '0; c1_addr = '0; c0_len = '0; c1_len = '0;
    c0_data = 64'h1111_2222_3333_4444;
    c1_data = 64'h5555_6666_7777_8888;
    tick();
    tick();
    chk("rst_grant", 64'(r_grant), 64'd0);
    chk("rst_req", 64'(r_req), 64'd0);
    chk("rst_err", 64'(r_err), 64'd0);
    chk("rst_addr", 64'(r_addr), 64'd0);
    chk("rst_len", 64'(r_len), 64'd0);
    chk("rst_data", r_data, 64'd0);
    chk("rst_fin", 64'({r_c1fin, r_c0fin}), 64'd0);
    chk("rst_fx_grant", 64'(f_grant), 64'd0);
    rst_n = 1'b1;
    last = 1'b1;
    exp_err = 1'b0;
    phase_start();

    c1_req = 1'b1; c1_addr = 27'h0012345; c1_len = 10'd128;
    burst("single_c1", -1, 2, 3, 1'b0);

    c0_req = 1'b1; c1_req = 1'b1; c0_len = 10'd4; c1_len = 10'd4;
    c0_addr = 27'h0000100; c1_addr = 27'h0000200;
    burst("both_first", -1, 0, 0, 1'b0);
    burst("both_second", -1, 1, 1, 1'b0);

    c1_req = 1'b1; c1_len = 10'd0; c1_addr = 27'h0000300;
    burst("zero_len", -1, 0, 0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(1, 3));
      c0_req  = r[0];
      c1_req  = r[1];
      c0_len  = LW'($urandom_range(0, 5));
      c1_len  = LW'($urandom_range(0, 5));
      c0_addr = AW'($urandom);
      c1_addr = AW'($urandom);
      burst("rnd", -1, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    end
    phase_end("rr");

    sel = 1'b1;
    do_reset();
    phase_start();
    c0_req = 1'b1; c1_req = 1'b1; c0_len = 10'd3; c1_len = 10'd2;
    c0_addr = 27'h0003000; c1_addr = 27'h0004000;
    for (int k = 0; k < 3; k++) burst("fixed_c0", -1, 0, 1, 1'b1);
    c0_req = 1'b0;
    burst("fixed_c1", -1, 0, 0, 1'b0);
    phase_end("fixed");

    sel = 1'b0;
    do_reset();
    phase_start();
    c0_req = 1'b1; c0_len = 10'd128; c0_addr = 27'h0005000;
    burst("short_finish", 127, 0, 2, 1'b0);
    c1_req = 1'b1; c1_len = 10'd3; c1_addr = 27'h0005800;
    burst("after_err", -1, 0, 0, 1'b0);
    phase_end("err");

    do_reset();
    c1_req = 1'b1; c1_len = 10'd100; c1_addr = 27'h0006000;
    t = 0;
    do begin
      tick();
      t++;
    end while (m_grant == 2'b00 && t < 40);
    chk("mid_grant", 64'(m_grant), 64'd2);
    c1_req = 1'b0;
    repeat (50) begin
      dreq = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(m_grant), 64'd0);
    chk("mid_rst_dr", 64'(m_c1dr), 64'd0);
    chk("mid_rst_req", 64'(m_req), 64'd0);
    chk("mid_rst_addr", 64'(m_addr), 64'd0);
    chk("mid_rst_len", 64'(m_len), 64'd0);
    do_reset();
    phase_start();
    c1_req = 1'b1; c1_len = 10'd5; c1_addr = 27'h0007000;
    burst("post_rst", -1, 1, 0, 1'b0);
    c0_req = 1'b1; c0_len = 10'd2; c0_addr = 27'h0007100;
    burst("timeout", -1, 0, TMO + 20, 1'b0);
    c1_req = 1'b1; c1_len = 10'd1; c1_addr = 27'h0007200;
    burst("post_timeout", -1, 0, 0, 1'b0);
    phase_end("tail");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ddr_wr_burst_arbiter.md
Name: ddr_wr_burst_arbiter

Overview:
- Two-client arbiter in front of the single DDR controller burst-write port.
- Client 0 is the video frame writer. Client 1 is the rectangle overlay writer, which issues per-line box bursts.
- Grants one client per burst, latches its address and length, and forwards them to the controller.
- Steers data_req, data and finish between the granted client and the controller; everything runs in the mem_clk domain.

Parameters:
- ADDR_W, 27, burst address width (64-bit word address space).
- LEN_W, 10, burst length width in 64-bit beats.
- DATA_W, 64, data width.
- FIXED_PRIO, 0, 0 = round-robin between clients; 1 = client 0 always wins.
- TIMEOUT, 4096, mem_clk cycles allowed from grant to finish before the error flag is set.

Ports:
- mem_clk  in  1  single clock.
- rst_n  in  1  asynchronous reset, active low.
- c0_wr_burst_req  in  1  client 0 request; level, held until data_req or finish.
- c0_wr_burst_addr  in  ADDR_W  client 0 start address.
- c0_wr_burst_len  in  LEN_W  client 0 beat count.
- c0_wr_burst_data  in  DATA_W  client 0 write data.
- c0_wr_burst_data_req  out  1  client 0 beat strobe.
- c0_burst_finish  out  1  client 0 done pulse.
- c1_wr_burst_req, c1_wr_burst_addr, c1_wr_burst_len, c1_wr_burst_data, c1_wr_burst_data_req, c1_burst_finish: same as client 0, for client 1.
- wr_burst_req  out  1  to controller.
- wr_burst_addr  out  ADDR_W  to controller.
- wr_burst_len  out  LEN_W  to controller.
- wr_burst_data  out  DATA_W  to controller.
- wr_burst_data_req  in  1  controller beat strobe.
- burst_finish  in  1  controller done pulse.
- grant  out  2  one-hot current owner; 00 when idle.
- arb_error  out  1  sticky error flag, cleared only by reset.

Behaviour:
- Reset: all outputs 0. State is IDLE. Round-robin pointer favours client 0. Beat counter and timeout counter are 0.
- States: IDLE, ISSUE, ACTIVE, DONE.
- IDLE:
  - Selects a client among those with req high.
  - FIXED_PRIO=1: client 0 wins.
  - Otherwise: the client not served last wins if both request; a single requester always wins.
  - Latches that client's addr/len into wr_burst_addr/wr_burst_len and sets grant.
  - If the latched len == 0, goes to DONE without asserting wr_burst_req (zero-length burst is absorbed locally; the overlay writer can emit len 0).
  - Otherwise goes to ISSUE.
- ISSUE:
  - wr_burst_req = 1 (registered), asserted the cycle after the grant decision.
  - Cleared on the first wr_burst_data_req or on burst_finish, then moves to ACTIVE; a finish arriving here moves directly to DONE.
- ACTIVE:
  - Waits for burst_finish, then goes to DONE.
- DONE:
  - Pulses the owner's cx_burst_finish for exactly 1 cycle.
  - Updates the round-robin pointer, clears grant, returns to IDLE.
  - Minimum 1 idle cycle between consecutive bursts.
  - Grant-decision-to-finish latency for a zero-length burst is 2 cycles.
- Steering:
  - cx_wr_burst_data_req = wr_burst_data_req & grant[x], combinational and zero latency.
  - wr_burst_data = owner's data, combinational mux; 0 when idle.
  - The non-owner never sees data_req or finish.
- Beat counter:
  - Cleared at grant; increments on each wr_burst_data_req while granted.
  - arb_error is set on any of:
    - burst_finish with count != latched len;
    - data_req when count == len;
    - data_req or finish while in IDLE;
    - timeout counter reaching TIMEOUT.
- Timeout: does not abort the burst; the arbiter keeps waiting for finish.
- Request edge cases:
  - A request dropped before grant is ignored.
  - A request that stays high after finish is re-arbitrated in IDLE as a new burst.
  - Requests arriving mid-burst wait in IDLE arbitration.
- Outside reset, no state is forced; frame-sync recovery is the clients' job.

Test Plan:
- Single client 1 request, addr 0x0012345, len 128. Controller asserts 128 data_req, then finish.
  -> grant=10; wr_burst_req high from grant+1 until the first data_req; 128 c1 data_req; one c1_burst_finish pulse; arb_error=0.
- Both clients request simultaneously, len 4 each, FIXED_PRIO=0.
  -> c0 served first, then c1; grant sequence 01, 00, 10; each client gets exactly 4 data_req.
- Same stimulus as the previous scenario with FIXED_PRIO=1, c0 requesting continuously.
  -> c1 never granted while c0 requests; c1 granted in the first IDLE after c0 drops.
- c1 request with len 0.
  -> wr_burst_req never asserted; c1_burst_finish pulses 2 cycles after the grant decision; arb_error=0.
- Controller returns finish after 127 beats for len 128.
  -> arb_error=1 and stays 1; arbiter returns to IDLE and serves the next request.
- rst_n asserted mid-ACTIVE after 50 beats, then released.
  -> all outputs 0 immediately; grant=00; next c1 request is granted normally with a fresh beat count.
